rr_arb_64b: RTL

// - Round-robin arbiter over 64 requesters. Selects one request per arbitration and presents it as a
//   one-hot grant plus a 6-bit index. The grant is held under a valid/ready handshake.
// - The one-hot to index conversion uses the team's enc_64b encoder, so the encoder's output register

---
 rtl/rr_arb_pkg.sv | 24 ++
 rtl/rr_arb_64b_enc_64b.sv | 36 +++
 rtl/rr_arb_64b.sv | 108 ++++++++++
 3 files changed

// File: rtl/rr_arb_pkg.sv
// Shared types and constants for the 64-way round-robin arbiter and its index encoder.
package rr_arb_pkg;

  localparam int N     = 64;
  localparam int IDX_W = 6;

  typedef enum logic [1:0] {IDLE, ENC, WAIT, GRANT} state_t;

  typedef logic [N-1:0]     vec_t;
  typedef logic [IDX_W-1:0] idx_t;

  // OR-reduce the positions of the set bits; exact for a one-hot input, 0 for all-zero.
  function automatic idx_t onehot_to_idx(input vec_t v);
    idx_t r;
    r = '0;
    for (int i = 0; i < N; i++) begin
      if (v[i]) begin
        r = r | idx_t'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arb_64b_enc_64b.sv
// One-hot to binary index encoder for 64 lanes, with optional output register.
module enc_64b
  import rr_arb_pkg::*;
#(
  parameter int OUT_REG = 1
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic in_valid,
  input  vec_t in_data,
  output logic out_valid,
  output idx_t out_data
);

  idx_t idx_p0;

  assign idx_p0 = onehot_to_idx(in_data);

  generate
    if (OUT_REG != 0) begin : g_reg
      // p0 -> p1: the index is a pure data register; only the valid is reset
      always_ff @(posedge clk_i) begin
        out_data <= idx_p0;
        if (!rst_n_i) begin
          out_valid <= 1'b0;
        end else begin
          out_valid <= in_valid;
        end
      end
    end else begin : g_comb
      assign out_data  = idx_p0;
      assign out_valid = in_valid;
    end
  endgenerate

endmodule

// File: rtl/rr_arb_64b.sv
// Round-robin arbiter over 64 requesters; one-hot grant plus index held under valid/ready.
module rr_arb_64b
  import rr_arb_pkg::*;
#(
  parameter int OUT_REG = 1
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [63:0] req_i,
  output logic [63:0] gnt_o,
  output logic [5:0]  gnt_idx_o,
  output logic        gnt_valid_o,
  input  logic        gnt_ready_i
);

  state_t state_q;
  idx_t   last_q;
  idx_t   idx_q;
  vec_t   oh_q;

  logic [N:0] lo_mask;
  vec_t       hi;
  vec_t       src;
  vec_t       oh;

  logic enc_in_valid;
  logic enc_out_valid;
  idx_t enc_out_data;

  // Priority mask: everything at or below last_q is demoted; 65-bit math makes last_q=63 mask all.
  always_comb begin
    lo_mask = ({{(N-1){1'b0}}, 2'b10} << last_q) - {{N{1'b0}}, 1'b1};
    hi      = req_i & ~lo_mask[N-1:0];
    src     = (|hi) ? hi : req_i;
    oh      = src & (~src + vec_t'(1));
  end

  assign enc_in_valid = (state_q == ENC);

  enc_64b #(
    .OUT_REG (OUT_REG)
  ) enc_64b (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .in_valid  (enc_in_valid),
    .in_data   (oh_q),
    .out_valid (enc_out_valid),
    .out_data  (enc_out_data)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      last_q      <= '1;
      oh_q        <= '0;
      gnt_o       <= '0;
      gnt_idx_o   <= '0;
      gnt_valid_o <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|req_i) begin
            oh_q    <= oh;
            state_q <= ENC;
          end
        end
        ENC: begin
          if (OUT_REG == 0) begin
            idx_q       <= enc_out_data;
            gnt_o       <= oh_q;
            gnt_idx_o   <= enc_out_data;
            gnt_valid_o <= 1'b1;
            state_q     <= GRANT;
          end else begin
            state_q <= WAIT;
          end
        end
        WAIT: begin
          idx_q       <= enc_out_data;
          gnt_o       <= oh_q;
          gnt_idx_o   <= enc_out_data;
          gnt_valid_o <= 1'b1;
          state_q     <= GRANT;
        end
        GRANT: begin
          // Outputs stay frozen until the consumer takes the grant.
          if (gnt_ready_i) begin
            last_q      <= idx_q;
            gnt_o       <= '0;
            gnt_idx_o   <= '0;
            gnt_valid_o <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  a_wait_enc_valid: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    (state_q == WAIT) |-> enc_out_valid);

  a_idx_matches_gnt: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    gnt_valid_o |-> (gnt_o == (vec_t'(1) << gnt_idx_o)));

endmodule
